// File: rtl/tile_move_ctrl.sv
// Move sequencer/arbiter for the 3x3 sliding-tile datapath: LFSR scrambler plus player channel.
// Optional one-level undo is enabled by defining TILE_CTRL_UNDO_EN.
module tile_move_ctrl #(
  parameter int unsigned SCRAMBLE_MOVES = 32,
  parameter int unsigned CNT_W          = 16,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scramble_start,
  input  logic             player_val,
  input  logic [1:0]       player_dir,
`ifdef TILE_CTRL_UNDO_EN
  input  logic             undo_req,
`endif
  output logic             player_rdy,
  input  logic             solved_in,
  output logic             move_en,
  output logic [1:0]       move_dir,
  output logic             move_reject,
  output logic [1:0]       space_row,
  output logic [1:0]       space_col,
  output logic [CNT_W-1:0] move_count,
  output logic             busy,
  output logic             game_won
);

  typedef enum logic [1:0] {StIdle, StScramble, StPlay, StWon} state_e;

  state_e             state_q, state_d;
  logic [7:0]         lfsr_q, remaining_q, remaining_d;
  logic [1:0]         prev_dir_q, prev_dir_d;
  logic               prev_valid_q, prev_valid_d;
  logic [1:0]         row_q, row_d, col_q, col_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               move_en_q, move_en_d, move_reject_q, move_reject_d;
  logic [1:0]         move_dir_q, move_dir_d;
  logic               issue;
  logic [1:0]         issue_dir, cand;
  logic               handshake, start_scr;
`ifdef TILE_CTRL_UNDO_EN
  logic [1:0]         last_dir_q, last_dir_d;
  logic               last_valid_q, last_valid_d;
`endif

  function automatic logic is_legal(input logic [1:0] d, input logic [1:0] r,
                                    input logic [1:0] c);
    case (d)
      2'b00:   return c != 2'd0;
      2'b01:   return c != 2'd2;
      2'b10:   return r != 2'd0;
      default: return r != 2'd2;
    endcase
  endfunction

  assign cand       = lfsr_q[1:0];
`ifdef TILE_CTRL_UNDO_EN
  assign player_rdy = (state_q == StPlay) && !move_en_q && !undo_req;
`else
  assign player_rdy = (state_q == StPlay) && !move_en_q;
`endif
  assign handshake  = player_val && player_rdy;
  assign start_scr  = scramble_start && (state_q != StScramble);

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    prev_dir_d    = prev_dir_q;
    prev_valid_d  = prev_valid_q;
    row_d         = row_q;
    col_d         = col_q;
    count_d       = count_q;
    move_en_d     = 1'b0;
    move_reject_d = 1'b0;
    move_dir_d    = move_dir_q;
    issue         = 1'b0;
    issue_dir     = 2'b00;
`ifdef TILE_CTRL_UNDO_EN
    last_dir_d    = last_dir_q;
    last_valid_d  = last_valid_q;
`endif
    if (start_scr) begin
      // A same-cycle player handshake is dropped here.
      state_d      = StScramble;
      remaining_d  = 8'(SCRAMBLE_MOVES);
      prev_valid_d = 1'b0;
`ifdef TILE_CTRL_UNDO_EN
      last_valid_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StScramble: begin
          if (is_legal(cand, row_q, col_q) &&
              !(prev_valid_q && (cand == (prev_dir_q ^ 2'b01)))) begin
            issue        = 1'b1;
            issue_dir    = cand;
            prev_dir_d   = cand;
            prev_valid_d = 1'b1;
            remaining_d  = remaining_q - 8'd1;
            if (remaining_q == 8'd1) begin
              state_d = StPlay;
              count_d = '0;
            end
          end
        end
        StPlay: begin
          // Win detection outranks a same-cycle player request.
          if (solved_in && !move_en_q && (count_q != '0)) begin
            state_d = StWon;
          end else if (handshake) begin
            if (is_legal(player_dir, row_q, col_q)) begin
              issue     = 1'b1;
              issue_dir = player_dir;
              if (count_q != '1) count_d = count_q + 1'b1;
`ifdef TILE_CTRL_UNDO_EN
              last_dir_d   = player_dir;
              last_valid_d = 1'b1;
`endif
            end else begin
              move_reject_d = 1'b1;
            end
          end
`ifdef TILE_CTRL_UNDO_EN
          else if (undo_req && last_valid_q && !move_en_q) begin
            issue        = 1'b1;
            issue_dir    = last_dir_q ^ 2'b01;
            count_d      = count_q - 1'b1;
            last_valid_d = 1'b0;
          end
`endif
        end
        default: ;
      endcase
    end
    if (issue) begin
      move_en_d  = 1'b1;
      move_dir_d = issue_dir;
      unique case (issue_dir)
        2'b00:   col_d = col_q - 2'd1;
        2'b01:   col_d = col_q + 2'd1;
        2'b10:   row_d = row_q - 2'd1;
        default: row_d = row_q + 2'd1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      lfsr_q        <= LFSR_SEED;
      remaining_q   <= '0;
      prev_dir_q    <= 2'b00;
      prev_valid_q  <= 1'b0;
      row_q         <= 2'd2;
      col_q         <= 2'd2;
      count_q       <= '0;
      move_en_q     <= 1'b0;
      move_reject_q <= 1'b0;
      move_dir_q    <= 2'b00;
`ifdef TILE_CTRL_UNDO_EN
      last_dir_q    <= 2'b00;
      last_valid_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      lfsr_q        <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      remaining_q   <= remaining_d;
      prev_dir_q    <= prev_dir_d;
      prev_valid_q  <= prev_valid_d;
      row_q         <= row_d;
      col_q         <= col_d;
      count_q       <= count_d;
      move_en_q     <= move_en_d;
      move_reject_q <= move_reject_d;
      move_dir_q    <= move_dir_d;
`ifdef TILE_CTRL_UNDO_EN
      last_dir_q    <= last_dir_d;
      last_valid_q  <= last_valid_d;
`endif
    end
  end

  assign move_en     = move_en_q;
  assign move_dir    = move_dir_q;
  assign move_reject = move_reject_q;
  assign space_row   = row_q;
  assign space_col   = col_q;
  assign move_count  = count_q;
  assign busy        = (state_q == StScramble);
  assign game_won    = (state_q == StWon);

endmodule

// File: tb/tb_tile_move_ctrl.sv
// Directed self-checking bench for tile_move_ctrl (scramble length 4).
// Define TILE_CTRL_UNDO_EN to also exercise the undo path.
module tb_tile_move_ctrl;
  localparam int CNT_W = 16;
  localparam logic [1:0] LEFT = 2'b00, RIGHT = 2'b01, UP = 2'b10, DOWN = 2'b11;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             scramble_start = 1'b0;
  logic             player_val = 1'b0;
  logic [1:0]       player_dir = 2'b00;
  logic             undo_req = 1'b0;
  logic             player_rdy, solved_in, move_en, move_reject, busy, game_won;
  logic [1:0]       move_dir, space_row, space_col;
  logic [CNT_W-1:0] move_count;

  int tests = 0;
  int fails = 0;
  int m_row = 2, m_col = 2, m_cnt = 0;

  tile_move_ctrl #(.SCRAMBLE_MOVES(4), .CNT_W(CNT_W), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .reset(reset), .scramble_start(scramble_start), .player_val(player_val),
    .player_dir(player_dir),
`ifdef TILE_CTRL_UNDO_EN
    .undo_req(undo_req),
`endif
    .player_rdy(player_rdy), .solved_in(solved_in), .move_en(move_en), .move_dir(move_dir),
    .move_reject(move_reject), .space_row(space_row), .space_col(space_col),
    .move_count(move_count), .busy(busy), .game_won(game_won)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_legal(input logic [1:0] d);
    if (d == LEFT) return m_col > 0;
    if (d == RIGHT) return m_col < 2;
    if (d == UP) return m_row > 0;
    return m_row < 2;
  endfunction

  task automatic m_apply(input logic [1:0] d);
    if (d == LEFT) m_col--;
    else if (d == RIGHT) m_col++;
    else if (d == UP) m_row--;
    else m_row++;
  endtask

  task automatic check_pos(input string name);
    tests++;
    if (space_row !== 2'(m_row) || space_col !== 2'(m_col)) begin
      fails++;
      $display("FAIL %s: blank (%0d,%0d) expected (%0d,%0d)", name, space_row, space_col,
               m_row, m_col);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    tests++;
    if ({busy, game_won, move_en, move_reject, player_rdy} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 00000",
               {busy, game_won, move_en, move_reject, player_rdy});
    end
    tests++;
    if (move_dir !== 2'b00 || move_count !== '0) begin
      fails++;
      $display("FAIL reset_dir_cnt: dir %b cnt %0d expected 00 / 0", move_dir, move_count);
    end
    check_pos("reset_pos");
    reset = 1'b0;
    tick();
  endtask

  task automatic test_idle_player;
    player_val = 1'b1;
    player_dir = DOWN;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (player_rdy !== 1'b0 || move_en !== 1'b0 || move_reject !== 1'b0) begin
        fails++;
        $display("FAIL idle_player: rdy %b en %b rej %b expected 0 0 0", player_rdy, move_en,
                 move_reject);
      end
    end
    player_val = 1'b0;
    check_pos("idle_pos");
    tests++;
    if (busy !== 1'b0 || game_won !== 1'b0) begin
      fails++;
      $display("FAIL idle_state: busy %b won %b expected 0 0", busy, game_won);
    end
  endtask

  task automatic test_reset_abort;
    scramble_start = 1'b1;
    tick();
    scramble_start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_busy: busy %b expected 1", busy);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests++;
      if (move_en !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL abort_quiet: en %b busy %b expected 0 0", move_en, busy);
      end
    end
    m_row = 2;
    m_col = 2;
    check_pos("abort_pos");
  endtask

  task automatic test_scramble(input string name);
    int pulses = 0;
    bit have_prev = 0;
    bit done = 0;
    logic [1:0] prev = 2'b00;
    scramble_start = 1'b1;
    tick();
    scramble_start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL %s_busy: busy %b expected 1", name, busy);
    end
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      if (move_en === 1'b1) begin
        tests++;
        if (!m_legal(move_dir) || (have_prev && move_dir == (prev ^ 2'b01))) begin
          fails++;
          $display("FAIL %s_move: dir %b at (%0d,%0d) prev %b expected legal non-inverse",
                   name, move_dir, m_row, m_col, prev);
        end
        m_apply(move_dir);
        prev = move_dir;
        have_prev = 1;
        pulses++;
      end
      if (busy !== 1'b1) done = 1;
    end
    tests++;
    if (!done || pulses != 4) begin
      fails++;
      $display("FAIL %s_count: done %0d pulses %0d expected 1 4", name, done, pulses);
    end
    check_pos({name, "_pos"});
    m_cnt = 0;
    tests++;
    if (move_count !== '0 || game_won !== 1'b0) begin
      fails++;
      $display("FAIL %s_end: cnt %0d won %b expected 0 0", name, move_count, game_won);
    end
  endtask

  task automatic do_move(input logic [1:0] d, input string name);
    bit legal;
    for (int i = 0; i < 10 && player_rdy !== 1'b1; i++) tick();
    tests++;
    if (player_rdy !== 1'b1) begin
      fails++;
      $display("FAIL %s_rdy: player_rdy %b expected 1", name, player_rdy);
    end
    legal = m_legal(d);
    player_val = 1'b1;
    player_dir = d;
    tick();
    player_val = 1'b0;
    tests++;
    if (move_en !== legal || move_reject !== !legal || (legal && move_dir !== d)) begin
      fails++;
      $display("FAIL %s_out: en %b rej %b dir %b expected %b %b %b", name, move_en, move_reject,
               move_dir, legal, !legal, d);
    end
    if (legal) begin
      m_apply(d);
      m_cnt++;
    end
    check_pos({name, "_pos"});
    tests++;
    if (move_count !== CNT_W'(m_cnt)) begin
      fails++;
      $display("FAIL %s_cnt: cnt %0d expected %0d", name, move_count, m_cnt);
    end
  endtask

  task automatic test_navigate;
    while (m_col < 2) do_move(RIGHT, "nav_right");
    while (m_row < 2) do_move(DOWN, "nav_down");
  endtask

`ifdef TILE_CTRL_UNDO_EN
  task automatic test_undo;
    int base = m_cnt;
    do_move(LEFT, "undo_left");
    tick();
    undo_req = 1'b1;
    tick();
    undo_req = 1'b0;
    tests++;
    if (move_en !== 1'b1 || move_dir !== RIGHT || move_count !== CNT_W'(base)) begin
      fails++;
      $display("FAIL undo_issue: en %b dir %b cnt %0d expected 1 01 %0d", move_en, move_dir,
               move_count, base);
    end
    m_apply(RIGHT);
    m_cnt = base;
    check_pos("undo_pos");
    tick();
    undo_req = 1'b1;
    tick();
    undo_req = 1'b0;
    tests++;
    if (move_en !== 1'b0 || move_count !== CNT_W'(base)) begin
      fails++;
      $display("FAIL undo_second: en %b cnt %0d expected 0 %0d", move_en, move_count, base);
    end
  endtask
`endif

  task automatic test_reject_then_legal;
    do_move(DOWN, "reject_down");
    tick();
    tests++;
    if (move_reject !== 1'b0 || move_en !== 1'b0) begin
      fails++;
      $display("FAIL reject_pulse: rej %b en %b expected 0 0", move_reject, move_en);
    end
    do_move(UP, "legal_up");
  endtask

  task automatic test_back_to_back;
    logic [1:0] dirs [3];
    logic [1:0] pend = 2'b00;
    int k = 0;
    dirs[0] = LEFT;
    dirs[1] = RIGHT;
    dirs[2] = LEFT;
    player_val = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (player_rdy !== 1'((i % 2) == 1) || move_en !== 1'((i % 2) == 0)) begin
        fails++;
        $display("FAIL b2b_%0d: rdy %b en %b expected %b %b", i, player_rdy, move_en,
                 1'((i % 2) == 1), 1'((i % 2) == 0));
      end
      if (i > 0 && (i % 2) == 0) begin
        m_apply(pend);
        m_cnt++;
      end
      if (i == 6) player_val = 1'b0;
      if ((i % 2) == 1) begin
        pend = dirs[k];
        player_dir = pend;
        k++;
      end
      if (i < 6) tick();
    end
    check_pos("b2b_pos");
    tests++;
    if (move_count !== CNT_W'(m_cnt)) begin
      fails++;
      $display("FAIL b2b_cnt: cnt %0d expected %0d", move_count, m_cnt);
    end
  endtask

  task automatic test_win;
    solved_in = 1'b1;
    tick();
    tests++;
    if (game_won !== 1'b0 || move_en !== 1'b0) begin
      fails++;
      $display("FAIL win_early: won %b en %b expected 0 0", game_won, move_en);
    end
    tick();
    tests++;
    if (game_won !== 1'b1) begin
      fails++;
      $display("FAIL win_state: won %b expected 1", game_won);
    end
    player_val = 1'b1;
    player_dir = LEFT;
    tick();
    tests++;
    if (player_rdy !== 1'b0 || move_en !== 1'b0 || move_count !== CNT_W'(m_cnt)) begin
      fails++;
      $display("FAIL win_hold: rdy %b en %b cnt %0d expected 0 0 %0d", player_rdy, move_en,
               move_count, m_cnt);
    end
    player_val = 1'b0;
    solved_in = 1'b0;
  endtask

  initial begin
    solved_in = 1'b0;
    test_reset();
    test_idle_player();
    test_reset_abort();
    test_scramble("scr1");
    test_navigate();
`ifdef TILE_CTRL_UNDO_EN
    test_undo();
`endif
    test_reject_then_legal();
    test_back_to_back();
    test_win();
    test_scramble("scr2");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tile_move_ctrl.md
Name: tile_move_ctrl

Overview:
- Move sequencer and arbiter for the 3x3 sliding-tile puzzle datapath.
- Shares the datapath's single move port between two sources: an internal LFSR scrambler and a player request channel.
- Keeps a shadow copy of the blank-space location, so it never issues an illegal move. Counts player moves and detects the win.

Parameters:
- SCRAMBLE_MOVES, 32, number of legal random moves issued per scramble (1..255).
- CNT_W, 16, width of the player move counter.
- LFSR_SEED, 8'hA5, reset value of the scrambler LFSR (nonzero).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- scramble_start  in  1  pulse; starts a scramble from IDLE, PLAY or WON
- player_val  in  1  player move request valid
- player_dir  in  2  requested direction: LEFT=00, RIGHT=01, UP=10, DOWN=11 (direction the blank moves)
- player_rdy  out  1  controller accepts a player move this cycle
- solved_in  in  1  datapath reports board equals goal arrangement
- move_en  out  1  one-cycle strobe; datapath applies move_dir
- move_dir  out  2  direction for the datapath; valid when move_en=1
- move_reject  out  1  one-cycle pulse; accepted player move was illegal
- space_row  out  2  shadow blank row (0..2)
- space_col  out  2  shadow blank column (0..2)
- move_count  out  CNT_W  accepted legal player moves since scramble end
- busy  out  1  high in SCRAMBLE
- game_won  out  1  high in WON

Behaviour:
- Reset:
  - State IDLE.
  - space_row=2, space_col=2.
  - move_count=0, LFSR=LFSR_SEED.
  - All 1-bit outputs 0, move_dir=00.
  - Reset asserted mid-scramble or mid-move aborts with no further move_en.
- Legality of a direction d against the shadow location:
  - LEFT needs col>0; RIGHT needs col<2; UP needs row>0; DOWN needs row<2.
  - The inverse of d is d^2'b01.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4.
  - Advances every cycle in every state except under reset.
- States:
  - IDLE:
    - player_rdy=0.
    - scramble_start -> SCRAMBLE; load remaining=SCRAMBLE_MOVES; clear prev-valid flag.
  - SCRAMBLE:
    - busy=1; scramble_start ignored.
    - Candidate d=LFSR[1:0] each cycle.
    - If d is legal and not the inverse of the previous scramble move (check skipped for the first move): next cycle move_en=1, move_dir=d.
    - On that same edge: shadow location updated, remaining decremented.
    - Otherwise no issue that cycle.
    - After the edge that issues the last move -> PLAY with move_count=0.
  - PLAY:
    - player_rdy = !move_en. This caps throughput at one move per two cycles, so the datapath settles before solved_in is sampled.
    - On handshake (player_val & player_rdy), the next cycle shows exactly one of:
      - legal: move_en=1, move_dir=player_dir, shadow updated, move_count+1 (saturates at all-ones);
      - illegal: move_reject=1, nothing else changes.
    - solved_in=1 while move_en=0 and move_count!=0 -> WON.
    - scramble_start -> SCRAMBLE. If a handshake occurs the same cycle, scramble_start wins and the player request is dropped.
  - WON:
    - game_won=1, player_rdy=0, move_count held.
    - scramble_start -> SCRAMBLE.
- Registers and timing:
  - move_en and move_reject are registered, one cycle after the decision.
  - Shadow location and count update on the same edge that raises move_en.

Optional Feature:
- TILE_CTRL_UNDO_EN.
- When defined:
  - Adds input undo_req (1 bit).
  - Player_rdy = PLAY & !move_en & !undo_req.
  - A one-level last-move register plus flag records the direction of each legal player move.
  - undo_req in PLAY with the flag set, and move_en=0: next cycle move_en=1 with the inverse direction, shadow updated, move_count-1, flag cleared.
  - undo_req with the flag clear does nothing.
  - The flag is cleared on reset and on scramble start.
- When undefined: no port, no registers, behaviour exactly as above.

Test Plan:
- Reset, then player_val=1 dir=DOWN with no scramble -> player_rdy=0, no move_en; space_row=2, space_col=2; state IDLE.
- SCRAMBLE_MOVES=4, pulse scramble_start -> exactly 4 move_en pulses, busy=1 until PLAY. No pulse is illegal or the inverse of its predecessor. Shadow matches an independent model. move_count=0 afterwards.
- In PLAY with blank at (2,2), send DOWN -> move_reject pulses one cycle later, no move_en, count unchanged. Then send UP -> move_en=1, move_dir=10, space_row=1, move_count=1.
- Back-to-back player_val held high -> player_rdy alternates 1,0. At most one move_en every two cycles.
- Drive solved_in=1 the cycle after a legal move with move_count=3 -> game_won=1 and player_rdy=0. Then scramble_start -> busy=1.
- (TILE_CTRL_UNDO_EN) Move LEFT from (2,2) to (2,1), then undo_req -> move_en with move_dir=01, blank back at (2,2), move_count 1->0. A second undo_req -> no move_en.
